// File: rtl/yc_pkg.sv
// Shared constants and config type for the luma/chroma line sequencer.
package yc_pkg;

  localparam logic [10:0] YC_BURST_START    = 11'd60;
  localparam logic [10:0] YC_BURST_END_FAST = 11'd140;
  localparam logic [10:0] YC_BURST_END_MID  = 11'd180;
  localparam logic [10:0] YC_BURST_END_SLOW = 11'd300;
  localparam logic [10:0] YC_HCNT_MAX       = 11'd1023;

  // Increment thresholds selecting the burst length, per video standard.
  localparam logic [39:0] PAL_FAST_THR  = 40'd120_000_000_000;
  localparam logic [39:0] PAL_SLOW_THR  = 40'd74_000_000_000;
  localparam logic [39:0] NTSC_FAST_THR = 40'd100_000_000_000;
  localparam logic [39:0] NTSC_SLOW_THR = 40'd59_000_000_000;

  localparam logic [7:0] NTSC_BURST_OFS  = 8'd132;
  localparam logic [7:0] PAL_BURST_OFS_A = 8'd96;
  localparam logic [7:0] PAL_BURST_OFS_B = 8'd160;

  typedef struct packed {
    logic [39:0] phase_inc;
    logic        pal;
  } yc_cfg_t;

endpackage

// File: rtl/yc_burst_window.sv
// Per-line horizontal counter and colourburst / active-chroma gate generation.
module yc_burst_window #(
  parameter logic [10:0] BURST_START = 11'd60,
  parameter logic [10:0] HCNT_MAX    = 11'd1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic [10:0] burst_end,
  output logic        burst_gate,
  output logic        active_gate
);

  logic [10:0] hcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt        <= '0;
      burst_gate  <= 1'b0;
      active_gate <= 1'b0;
    end else begin
      if (hsync) begin
        hcnt <= '0;
      end else if (hcnt < HCNT_MAX) begin
        hcnt <= hcnt + 11'd1;
      end
      // Gates follow burst_end live, so a mode change takes effect mid-line.
      burst_gate  <= ~hsync & (hcnt >= BURST_START) & (hcnt <= burst_end);
      active_gate <= ~hsync & (hcnt > burst_end);
    end
  end

endmodule

// File: rtl/yc_line_sequencer.sv
// Subcarrier accumulator, double-buffered config, PAL V-switch and line timing
// for the composite/S-video chroma encoder.
module yc_line_sequencer
  import yc_pkg::*;
#(
  parameter logic [39:0] DEF_PHASE_INC  = 40'd0,
  parameter logic [10:0] BURST_START    = YC_BURST_START,
  parameter logic [10:0] BURST_END_FAST = YC_BURST_END_FAST,
  parameter logic [10:0] BURST_END_MID  = YC_BURST_END_MID,
  parameter logic [10:0] BURST_END_SLOW = YC_BURST_END_SLOW,
  parameter logic [10:0] HCNT_MAX       = YC_HCNT_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [39:0] cfg_phase_inc,
  input  logic        cfg_pal,
  input  logic        hsync,
  input  logic        vsync,
  output logic [39:0] phase_inc,
  output logic        pal_en,
  output logic [7:0]  sc_lut,
  output logic [7:0]  burst_ofs,
  output logic        burst_gate,
  output logic        active_gate,
  output logic        pal_flip,
  output logic [9:0]  line_cnt
);

  logic        hs_d, vs_d;
  logic        hs_rise, vs_rise;
  yc_cfg_t     pend_q;
  yc_cfg_t     act_d;
  logic [39:0] acc;
  logic [10:0] burst_end, burst_end_d;

  assign hs_rise = hsync & ~hs_d;
  assign vs_rise = vsync & ~vs_d;

  // A write coinciding with vsync bypasses the pending stage.
  always_comb begin
    act_d = pend_q;
    if (cfg_we) begin
      act_d.phase_inc = cfg_phase_inc;
      act_d.pal       = cfg_pal;
    end
  end

  always_comb begin
    burst_end_d = BURST_END_MID;
    if (act_d.pal) begin
      if (act_d.phase_inc > PAL_FAST_THR) begin
        burst_end_d = BURST_END_FAST;
      end else if (act_d.phase_inc < PAL_SLOW_THR) begin
        burst_end_d = BURST_END_SLOW;
      end
    end else begin
      if (act_d.phase_inc > NTSC_FAST_THR) begin
        burst_end_d = BURST_END_FAST;
      end else if (act_d.phase_inc < NTSC_SLOW_THR) begin
        burst_end_d = BURST_END_SLOW;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hs_d             <= 1'b0;
      vs_d             <= 1'b0;
      pend_q.phase_inc <= DEF_PHASE_INC;
      pend_q.pal       <= 1'b0;
      phase_inc        <= DEF_PHASE_INC;
      pal_en           <= 1'b0;
      burst_end        <= BURST_END_MID;
      acc              <= '0;
      sc_lut           <= '0;
      pal_flip         <= 1'b0;
      burst_ofs        <= NTSC_BURST_OFS;
      line_cnt         <= '0;
    end else begin
      hs_d <= hsync;
      vs_d <= vsync;
      if (cfg_we) begin
        pend_q.phase_inc <= cfg_phase_inc;
        pend_q.pal       <= cfg_pal;
      end
      if (vs_rise) begin
        phase_inc <= act_d.phase_inc;
        pal_en    <= act_d.pal;
        burst_end <= burst_end_d;
      end

      acc    <= acc + phase_inc;
      sc_lut <= acc[39:32];

      if (!pal_en) begin
        pal_flip <= 1'b0;
      end else if (hs_rise) begin
        pal_flip <= ~pal_flip;
      end

      if (!pal_en) begin
        burst_ofs <= NTSC_BURST_OFS;
      end else begin
        burst_ofs <= pal_flip ? PAL_BURST_OFS_B : PAL_BURST_OFS_A;
      end

      if (vs_rise) begin
        line_cnt <= '0;
      end else if (hs_rise && (line_cnt != 10'd1023)) begin
        line_cnt <= line_cnt + 10'd1;
      end
    end
  end

  yc_burst_window #(
    .BURST_START (BURST_START),
    .HCNT_MAX    (HCNT_MAX)
  ) u_burst_window (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .burst_end   (burst_end),
    .burst_gate  (burst_gate),
    .active_gate (active_gate)
  );

endmodule

// File: tb/tb_yc_line_sequencer.sv
// Directed and randomized bench for yc_line_sequencer against a behavioural model.
module tb_yc_line_sequencer;

  logic        clk;
  logic        reset;
  logic        cfg_we;
  logic [39:0] cfg_phase_inc;
  logic        cfg_pal;
  logic        hsync;
  logic        vsync;
  logic [39:0] phase_inc;
  logic        pal_en;
  logic [7:0]  sc_lut;
  logic [7:0]  burst_ofs;
  logic        burst_gate;
  logic        active_gate;
  logic        pal_flip;
  logic [9:0]  line_cnt;

  int checks;
  int failures;

  // Reference model state
  longint m_acc, m_inc, m_pinc;
  int     m_sc, m_hcnt, m_bend, m_ofs, m_line;
  bit     m_bg, m_ag, m_flip, m_pal, m_ppal, m_hs, m_vs;

  yc_line_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .cfg_we        (cfg_we),
    .cfg_phase_inc (cfg_phase_inc),
    .cfg_pal       (cfg_pal),
    .hsync         (hsync),
    .vsync         (vsync),
    .phase_inc     (phase_inc),
    .pal_en        (pal_en),
    .sc_lut        (sc_lut),
    .burst_ofs     (burst_ofs),
    .burst_gate    (burst_gate),
    .active_gate   (active_gate),
    .pal_flip      (pal_flip),
    .line_cnt      (line_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int burst_end_ref(input longint inc, input bit pal);
    real f;
    f = real'(inc);
    if (f > (pal ? 120.0e9 : 100.0e9)) return 140;
    if (f < (pal ? 74.0e9 : 59.0e9)) return 300;
    return 180;
  endfunction

  task automatic model_reset();
    m_acc = 0; m_inc = 0; m_pinc = 0; m_sc = 0; m_hcnt = 0; m_bend = 180;
    m_ofs = 132; m_line = 0; m_bg = 0; m_ag = 0; m_flip = 0; m_pal = 0;
    m_ppal = 0; m_hs = 0; m_vs = 0;
  endtask

  // One clock of the specified behaviour, all next values from current state.
  task automatic model_clock();
    bit     hs_rise, vs_rise, n_pal, n_ppal, n_flip, n_bg, n_ag;
    longint n_inc, n_pinc, n_acc;
    int     n_bend, n_hcnt, n_ofs, n_line, n_sc;
    hs_rise = hsync && !m_hs;
    vs_rise = vsync && !m_vs;
    n_inc = m_inc; n_pal = m_pal; n_pinc = m_pinc; n_ppal = m_ppal; n_bend = m_bend;
    if (cfg_we) begin
      n_pinc = longint'(cfg_phase_inc);
      n_ppal = cfg_pal;
    end
    if (vs_rise) begin
      n_inc  = n_pinc;
      n_pal  = n_ppal;
      n_bend = burst_end_ref(n_inc, n_pal);
    end
    n_sc   = int'(m_acc / 64'd4294967296);
    n_acc  = (m_acc + m_inc) % 64'h100_0000_0000;
    n_bg   = !hsync && (m_hcnt >= 60) && (m_hcnt <= m_bend);
    n_ag   = !hsync && (m_hcnt > m_bend);
    n_hcnt = hsync ? 0 : ((m_hcnt + 1 > 1023) ? 1023 : m_hcnt + 1);
    n_flip = m_pal ? (hs_rise ? !m_flip : m_flip) : 1'b0;
    n_ofs  = !m_pal ? 132 : (m_flip ? 160 : 96);
    if (vs_rise) n_line = 0;
    else if (hs_rise) n_line = (m_line == 1023) ? 1023 : m_line + 1;
    else n_line = m_line;
    m_inc = n_inc; m_pal = n_pal; m_pinc = n_pinc; m_ppal = n_ppal; m_bend = n_bend;
    m_sc = n_sc; m_acc = n_acc; m_bg = n_bg; m_ag = n_ag; m_hcnt = n_hcnt;
    m_flip = n_flip; m_ofs = n_ofs; m_line = n_line; m_hs = hsync; m_vs = vsync;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("phase_inc", 64'(phase_inc), 64'(m_inc));
    chk("pal_en", 64'(pal_en), 64'(m_pal));
    chk("sc_lut", 64'(sc_lut), 64'(m_sc));
    chk("burst_ofs", 64'(burst_ofs), 64'(m_ofs));
    chk("burst_gate", 64'(burst_gate), 64'(m_bg));
    chk("active_gate", 64'(active_gate), 64'(m_ag));
    chk("pal_flip", 64'(pal_flip), 64'(m_flip));
    chk("line_cnt", 64'(line_cnt), 64'(m_line));
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  function automatic logic [39:0] rand_inc();
    logic [39:0] v;
    case ($urandom_range(0, 5))
      0: v = 40'd120_000_000_000;
      1: v = 40'd74_000_000_000;
      2: v = 40'd100_000_000_000 + 40'($urandom_range(0, 2)) - 40'd1;
      3: v = 40'd59_000_000_000 + 40'($urandom_range(0, 2)) - 40'd1;
      4: v = 40'd40_000_000_000 + 40'($urandom_range(0, 100_000_000)) * 40'd1000;
      default: v = {8'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  initial begin
    int first, bg_cnt, len, vs_off;
    bit vs_line;
    checks = 0; failures = 0;
    reset = 1'b1; cfg_we = 1'b0; cfg_phase_inc = '0; cfg_pal = 1'b0;
    hsync = 1'b0; vsync = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 reset = 1'b0;

    // Default NTSC line: burst window hcnt 60..180
    hsync = 1'b1;
    repeat (10) step();
    hsync = 1'b0;
    first = -1; bg_cnt = 0;
    for (int i = 1; i <= 400; i++) begin
      step();
      if (burst_gate === 1'b1) begin
        bg_cnt++;
        if (first < 0) first = i;
      end
    end
    chk("t1_burst_first", 64'(first), 64'd61);
    chk("t1_burst_len", 64'(bg_cnt), 64'd121);

    // Pending PAL config waits for vsync, then shortens burst
    cfg_we = 1'b1; cfg_phase_inc = 40'd130_000_000_000; cfg_pal = 1'b1;
    step();
    cfg_we = 1'b0;
    repeat (5) step();
    chk("t2_inc_held", 64'(phase_inc), 64'd0);
    vsync = 1'b1; step(); vsync = 1'b0; step();
    chk("t2_inc_new", 64'(phase_inc), 64'd130_000_000_000);
    hsync = 1'b1; repeat (3) step(); hsync = 1'b0;
    bg_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (burst_gate === 1'b1) bg_cnt++;
    end
    chk("t2_burst_len", 64'(bg_cnt), 64'd81);

    // PAL V-switch over several lines, then back to NTSC
    for (int p = 0; p < 4; p++) begin
      hsync = 1'b1; repeat (2) step(); hsync = 1'b0;
      repeat (20) step();
    end
    cfg_we = 1'b1; cfg_phase_inc = 40'd80_000_000_000; cfg_pal = 1'b0; vsync = 1'b1;
    step();
    cfg_we = 1'b0; vsync = 1'b0;
    repeat (2) step();
    chk("t3_flip_ntsc", 64'(pal_flip), 64'd0);
    chk("t3_ofs_ntsc", 64'(burst_ofs), 64'd132);

    // Accumulator wrap behaviour
    cfg_we = 1'b1; cfg_phase_inc = 40'h01_0000_0000; vsync = 1'b1;
    step();
    cfg_we = 1'b0; vsync = 1'b0;
    repeat (300) step();
    cfg_we = 1'b1; cfg_phase_inc = 40'h80_0000_0000; vsync = 1'b1;
    step();
    cfg_we = 1'b0; vsync = 1'b0;
    repeat (10) step();

    // Coincident cfg_we/vsync, and coincident hsync/vsync rises
    cfg_we = 1'b1; cfg_phase_inc = 40'd50_000_000_000; cfg_pal = 1'b0; vsync = 1'b1;
    step();
    chk("t5_inc_bypass", 64'(phase_inc), 64'd50_000_000_000);
    cfg_we = 1'b0; vsync = 1'b0;
    hsync = 1'b1; step(); hsync = 1'b0;
    repeat (3) step();
    hsync = 1'b1; vsync = 1'b1; step();
    chk("t5_line_zero", 64'(line_cnt), 64'd0);
    hsync = 1'b0; vsync = 1'b0;
    repeat (3) step();

    // Randomized lines, configs and field syncs
    for (int ln = 0; ln < 24; ln++) begin
      len = $urandom_range(120, 420);
      vs_line = ($urandom_range(0, 3) == 0);
      vs_off = $urandom_range(0, 8);
      for (int c = 0; c < len; c++) begin
        hsync = (c < 4);
        vsync = vs_line && (c >= vs_off) && (c < vs_off + 5);
        cfg_we = ($urandom_range(0, 40) == 0);
        if (cfg_we) begin
          cfg_phase_inc = rand_inc();
          cfg_pal = 1'($urandom_range(0, 1));
        end
        step();
      end
    end
    cfg_we = 1'b0; vsync = 1'b0;

    // Long line saturates hcnt; set a known slow-burst NTSC config first
    cfg_we = 1'b1; cfg_phase_inc = 40'd50_000_000_000; cfg_pal = 1'b0; vsync = 1'b1;
    step();
    cfg_we = 1'b0; vsync = 1'b0;
    hsync = 1'b1; repeat (2) step(); hsync = 1'b0;
    repeat (1100) step();
    chk("t6_active_sat", 64'(active_gate), 64'd1);

    // Async reset mid-burst
    hsync = 1'b1; repeat (2) step(); hsync = 1'b0;
    repeat (80) step();
    chk("t6_in_burst", 64'(burst_gate), 64'd1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    #2 reset = 1'b0;
    repeat (5) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
